// File: rtl/vector_wb_unit.sv
// Writeback sequencer for the 4-lane x 32-bit vector register file write port.
// Merges buffered ALU results with word-serial load results and tracks pending loads.
module vector_wb_unit #(
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [3:0]  alu_mask,
    input  logic [31:0] alu_data [3:0],
    input  logic        ld_start,
    input  logic [4:0]  ld_addr,
    input  logic [3:0]  ld_mask,
    output logic        ld_busy,
    input  logic        ld_word_valid,
    input  logic [31:0] ld_word,
    output logic [4:0]  write_addr,
    output logic [31:0] write_vector [3:0],
    output logic [3:0]  we,
    output logic [31:0] pending
);

    localparam int AW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE
    } ld_state_t;

    // ALU result FIFO; pointers carry one extra wrap bit to tell full from empty
    logic [4:0]    fifo_addr_mem [ALU_FIFO_DEPTH];
    logic [3:0]    fifo_mask_mem [ALU_FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [4:0]    head_addr;
    logic [3:0]    head_mask;
    logic [31:0]   head_data [3:0];

    ld_state_t     state_reg;
    ld_state_t     state_next;
    logic [4:0]    ld_addr_reg;
    logic [3:0]    ld_mask_reg;
    logic [3:0]    rem_mask_reg;
    logic [3:0]    rem_mask_next;
    logic [3:0]    lane_onehot;
    logic [31:0]   lane_buf_reg [3:0];
    logic          ld_accept;
    logic          word_take;

    logic          issue_load;
    logic          issue_valid;
    logic [4:0]    issue_addr;
    logic [3:0]    issue_mask;
    logic [31:0]   issue_data [3:0];
    logic [31:0]   pending_set;
    logic [31:0]   pending_clr;

    assign wr_idx     = wr_ptr_reg[AW-1:0];
    assign rd_idx     = rd_ptr_reg[AW-1:0];
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign alu_ready  = !fifo_full;
    assign fifo_push  = alu_valid && !fifo_full;
    assign issue_load = (state_reg == ST_WRITE);
    assign fifo_pop   = !issue_load && !fifo_empty;
    assign head_addr  = fifo_addr_mem[rd_idx];
    assign head_mask  = fifo_mask_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_addr_mem[wr_idx] <= alu_addr;
            fifo_mask_mem[wr_idx] <= alu_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Load assembler
    assign ld_busy     = (state_reg != ST_IDLE);
    assign ld_accept   = (state_reg == ST_IDLE) && ld_start && (ld_mask != 4'd0);
    assign word_take   = (state_reg == ST_COLLECT) && ld_word_valid;
    // Lowest still-unfilled lane receives the next word
    assign lane_onehot = rem_mask_reg & (~rem_mask_reg + 4'd1);

    always_comb begin
        state_next    = state_reg;
        rem_mask_next = rem_mask_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ld_accept) begin
                    state_next    = ST_COLLECT;
                    rem_mask_next = ld_mask;
                end
            end
            ST_COLLECT: begin
                if (word_take) begin
                    rem_mask_next = rem_mask_reg & ~lane_onehot;
                    if (rem_mask_next == 4'd0) state_next = ST_WRITE;
                end
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rem_mask_reg <= '0;
            ld_addr_reg  <= '0;
            ld_mask_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            rem_mask_reg <= rem_mask_next;
            if (ld_accept) begin
                ld_addr_reg <= ld_addr;
                ld_mask_reg <= ld_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) lane_buf_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ld_accept)
                    lane_buf_reg[i] <= '0;
                else if (word_take && lane_onehot[i])
                    lane_buf_reg[i] <= ld_word;
            end
        end
    end

    // Arbitration: a load in WRITE always wins the port for that edge
    assign issue_valid = issue_load || fifo_pop;
    assign issue_addr  = issue_load ? ld_addr_reg : head_addr;
    assign issue_mask  = issue_load ? ld_mask_reg : head_mask;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [31:0] data_mem [ALU_FIFO_DEPTH];

            always_ff @(posedge clk) begin
                if (fifo_push) data_mem[wr_idx] <= alu_data[gi];
            end

            assign head_data[gi]  = data_mem[rd_idx];
            assign issue_data[gi] = !issue_mask[gi] ? 32'd0 :
                                    (issue_load ? lane_buf_reg[gi] : head_data[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_addr <= '0;
            we         <= '0;
            for (int i = 0; i < 4; i++) write_vector[i] <= '0;
        end else if (issue_valid) begin
            write_addr <= issue_addr;
            we         <= issue_mask;
            for (int i = 0; i < 4; i++) write_vector[i] <= issue_data[i];
        end else begin
            we <= '0;
        end
    end

    // Scoreboard: a same-edge set beats a clear of the same register
    assign pending_set = ld_accept  ? (32'd1 << ld_addr)     : 32'd0;
    assign pending_clr = issue_load ? (32'd1 << ld_addr_reg) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~pending_clr) | pending_set;
    end

endmodule

// File: tb/tb_vector_wb_unit.sv
// Scoreboard bench for vector_wb_unit: expected writes queued at stimulus time,
// popped and compared (addr, mask, lanes, issue cycle) whenever we is nonzero.
module tb_vector_wb_unit;

    typedef struct packed {
        logic [4:0]   addr;
        logic [3:0]   mask;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [3:0]  alu_mask = '0;
    logic [31:0] alu_data [3:0];
    logic        ld_start = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [3:0]  ld_mask = '0;
    logic        ld_busy;
    logic        ld_word_valid = 1'b0;
    logic [31:0] ld_word = '0;
    logic [4:0]  write_addr;
    logic [31:0] write_vector [3:0];
    logic [3:0]  we;
    logic [31:0] pending;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    vector_wb_unit #(.ALU_FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_addr(alu_addr), .alu_mask(alu_mask), .alu_data(alu_data),
        .ld_start(ld_start), .ld_addr(ld_addr), .ld_mask(ld_mask),
        .ld_busy(ld_busy), .ld_word_valid(ld_word_valid), .ld_word(ld_word),
        .write_addr(write_addr), .write_vector(write_vector), .we(we),
        .pending(pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: every nonzero write enable must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && we != 4'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_we", {124'd0, we}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", {123'd0, write_addr}, {123'd0, e.addr});
                check("wr_we", {124'd0, we}, {124'd0, e.mask});
                for (int i = 0; i < 4; i++)
                    check($sformatf("wr_lane%0d", i), {96'd0, write_vector[i]},
                          {96'd0, e.data[32*i +: 32]});
                if (e.cyc >= 0)
                    check("wr_cycle", 128'(cyc), 128'(e.cyc));
                $display("write addr=%0d we=%b data=%h_%h_%h_%h cyc=%0d", write_addr, we,
                         write_vector[3], write_vector[2], write_vector[1], write_vector[0], cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic push_exp(input logic [4:0] a, input logic [3:0] m,
                            input logic [127:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.mask = m;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic set_alu(input logic [4:0] a, input logic [3:0] m, input logic [127:0] d);
        alu_addr = a;
        alu_mask = m;
        for (int i = 0; i < 4; i++) alu_data[i] = d[32*i +: 32];
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_left", 128'(sb.size()), 128'd0);
        step();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) alu_data[i] = '0;

        // Reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("rst_we", {124'd0, we}, 128'd0);
        check("rst_pending", {96'd0, pending}, 128'd0);
        check("rst_ld_busy", {127'd0, ld_busy}, 128'd0);
        check("rst_alu_ready", {127'd0, alu_ready}, 128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // ALU single write
        set_alu(5'd5, 4'b1111, pack4(32'd1, 32'd2, 32'd3, 32'd4));
        alu_valid = 1'b1;
        push_exp(5'd5, 4'b1111, pack4(32'd1, 32'd2, 32'd3, 32'd4), cyc + 2);
        step();
        alu_valid = 1'b0;
        drain();
        check("alu_single_we_low", {124'd0, we}, 128'd0);

        // Masked load: lanes 1 and 3
        ld_start = 1'b1; ld_addr = 5'd9; ld_mask = 4'b1010;
        step();
        ld_start = 1'b0;
        check("ld_pending_set", {96'd0, pending}, {96'd0, 32'd1 << 9});
        check("ld_busy_high", {127'd0, ld_busy}, 128'd1);
        ld_word_valid = 1'b1; ld_word = 32'hAAAA;
        step();
        ld_word = 32'hBBBB;
        push_exp(5'd9, 4'b1010, pack4(32'd0, 32'hAAAA, 32'd0, 32'hBBBB), cyc + 2);
        step();
        ld_word_valid = 1'b0;
        check("ld_pending_in_write", {96'd0, pending}, {96'd0, 32'd1 << 9});
        step();
        check("ld_pending_clear", {96'd0, pending}, 128'd0);
        check("ld_busy_fall", {127'd0, ld_busy}, 128'd0);
        drain();

        // FIFO full: a load WRITE stalls issue for one cycle
        ld_start = 1'b1; ld_addr = 5'd7; ld_mask = 4'b0001;
        step();
        ld_start = 1'b0;
        ld_word_valid = 1'b1; ld_word = 32'h77;
        set_alu(5'd1, 4'b0011, pack4(32'h11, 32'h12, 32'h13, 32'h14));
        alu_valid = 1'b1;
        push_exp(5'd7, 4'b0001, pack4(32'h77, 32'd0, 32'd0, 32'd0), -1);
        push_exp(5'd1, 4'b0011, pack4(32'h11, 32'h12, 32'd0, 32'd0), -1);
        step();
        ld_word_valid = 1'b0;
        check("full_ready_one", {127'd0, alu_ready}, 128'd1);
        set_alu(5'd2, 4'b1100, pack4(32'h21, 32'h22, 32'h23, 32'h24));
        push_exp(5'd2, 4'b1100, pack4(32'd0, 32'd0, 32'h23, 32'h24), -1);
        step();
        check("full_ready_low", {127'd0, alu_ready}, 128'd0);
        set_alu(5'd3, 4'b0101, pack4(32'h31, 32'h32, 32'h33, 32'h34));
        push_exp(5'd3, 4'b0101, pack4(32'h31, 32'd0, 32'h33, 32'd0), -1);
        n = 0;
        while (!alu_ready && n < 10) begin
            step();
            n++;
        end
        check("full_ready_timeout", {127'd0, alu_ready}, 128'd1);
        step();
        alu_valid = 1'b0;
        drain();

        // Collision: load WRITE while FIFO holds addr 3
        ld_start = 1'b1; ld_addr = 5'd12; ld_mask = 4'b0110;
        step();
        ld_start = 1'b0;
        ld_word_valid = 1'b1; ld_word = 32'hC1;
        step();
        ld_word = 32'hC2;
        set_alu(5'd3, 4'b1111, pack4(32'h301, 32'h302, 32'h303, 32'h304));
        alu_valid = 1'b1;
        push_exp(5'd12, 4'b0110, pack4(32'd0, 32'hC1, 32'hC2, 32'd0), cyc + 2);
        push_exp(5'd3, 4'b1111, pack4(32'h301, 32'h302, 32'h303, 32'h304), cyc + 3);
        step();
        ld_word_valid = 1'b0;
        alu_valid = 1'b0;
        drain();

        // Ignored inputs: words in IDLE/WRITE, ld_start while busy, zero mask
        ld_word_valid = 1'b1; ld_word = 32'hDEAD;
        step();
        step();
        ld_word_valid = 1'b0;
        ld_start = 1'b1; ld_addr = 5'd20; ld_mask = 4'b0011;
        step();
        ld_addr = 5'd21; ld_mask = 4'b1111;
        ld_word_valid = 1'b1; ld_word = 32'h2001;
        step();
        ld_start = 1'b0;
        ld_word = 32'h2002;
        push_exp(5'd20, 4'b0011, pack4(32'h2001, 32'h2002, 32'd0, 32'd0), cyc + 2);
        step();
        ld_word = 32'hBEEF;
        check("ign_pending_write", {96'd0, pending}, {96'd0, 32'd1 << 20});
        step();
        check("ign_pending_clear", {96'd0, pending}, 128'd0);
        step();
        ld_word_valid = 1'b0;
        ld_start = 1'b1; ld_addr = 5'd4; ld_mask = 4'b0000;
        step();
        ld_start = 1'b0;
        check("zero_mask_busy", {127'd0, ld_busy}, 128'd0);
        check("zero_mask_pending", {96'd0, pending}, 128'd0);
        drain();

        // Abort: reset after 1 of 4 words
        ld_start = 1'b1; ld_addr = 5'd15; ld_mask = 4'b1111;
        step();
        ld_start = 1'b0;
        ld_word_valid = 1'b1; ld_word = 32'hF1;
        step();
        ld_word_valid = 1'b0;
        check("abort_pending_set", {96'd0, pending}, {96'd0, 32'd1 << 15});
        #3 rst_n = 1'b0;
        #1;
        check("abort_we", {124'd0, we}, 128'd0);
        check("abort_pending", {96'd0, pending}, 128'd0);
        check("abort_ld_busy", {127'd0, ld_busy}, 128'd0);
        check("abort_alu_ready", {127'd0, alu_ready}, 128'd1);
        check("abort_write_addr", {123'd0, write_addr}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ld_word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_word = 32'hF2 + i;
            step();
        end
        ld_word_valid = 1'b0;
        repeat (5) step();
        check("abort_no_write", {124'd0, we}, 128'd0);
        check("abort_sb_empty", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
